// File: rtl/text_fetch_pipe.sv
// Three-stage text-mode fetch pipeline: cell address -> VRAM word -> glyph code and palette colors.
// The timing strobes travel alongside so every output is the input delayed by exactly three clocks.
module text_fetch_pipe (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        vde,
   input  logic        hsync,
   input  logic        vsync,
   output logic [10:0] vram_addr,
   output logic        vram_re,
   input  logic [31:0] vram_rdata,
   input  logic        pal_we,
   input  logic [3:0]  pal_waddr,
   input  logic [11:0] pal_wdata,
   output logic [7:0]  draw_code,
   output logic [31:0] draw_sig,
   output logic [9:0]  DrawX_o,
   output logic [9:0]  DrawY_o,
   output logic        vde_o,
   output logic        hsync_o,
   output logic        vsync_o
);

   logic [11:0] palette_r [0:15];

   logic [9:0]  s1_drawx_r, s1_drawy_r;
   logic        s1_vde_r, s1_hsync_r, s1_vsync_r, s1_col0_r;
   logic [9:0]  s2_drawx_r, s2_drawy_r;
   logic        s2_vde_r, s2_hsync_r, s2_vsync_r, s2_col0_r;

   logic [5:0]  row_s;
   logic [10:0] cell_addr_s;
   logic [15:0] cell_s;
   logic [11:0] fg_s, bg_s;

   // Word address of the cell pair: row*40 built as row*32 + row*8, plus col/2.
   always_comb begin
      row_s       = DrawY[9:4];
      cell_addr_s = {row_s, 5'b00000} + {2'b00, row_s, 3'b000} + {5'b00000, DrawX[9:4]};
   end

   // Stage 3 combinational decode: pick the halfword for this column and look up its colors.
   always_comb begin
      if (s2_col0_r) begin
         cell_s = vram_rdata[31:16];
      end else begin
         cell_s = vram_rdata[15:0];
      end
      fg_s = palette_r[cell_s[7:4]];
      bg_s = palette_r[cell_s[3:0]];
   end

   // Palette storage; a write lands after the edge, so a same-edge lookup still sees the old entry.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < 16; i++) begin
            palette_r[i] <= 12'h000;
         end
      end else if (pal_we) begin
         palette_r[pal_waddr] <= pal_wdata;
      end
   end

   // Stage 1: issue the VRAM read and capture the timing strobes.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vram_addr  <= 11'd0;
         vram_re    <= 1'b0;
         s1_drawx_r <= 10'd0;
         s1_drawy_r <= 10'd0;
         s1_vde_r   <= 1'b0;
         s1_hsync_r <= 1'b0;
         s1_vsync_r <= 1'b0;
         s1_col0_r  <= 1'b0;
      end else begin
         // Address only moves during active video so it never leaves 0..1199.
         if (vde) begin
            vram_addr <= cell_addr_s;
            vram_re   <= 1'b1;
         end else begin
            vram_re   <= 1'b0;
         end
         s1_drawx_r <= DrawX;
         s1_drawy_r <= DrawY;
         s1_vde_r   <= vde;
         s1_hsync_r <= hsync;
         s1_vsync_r <= vsync;
         s1_col0_r  <= DrawX[3];
      end
   end

   // Stage 2: delay slot matching the one-cycle VRAM read latency.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s2_drawx_r <= 10'd0;
         s2_drawy_r <= 10'd0;
         s2_vde_r   <= 1'b0;
         s2_hsync_r <= 1'b0;
         s2_vsync_r <= 1'b0;
         s2_col0_r  <= 1'b0;
      end else begin
         s2_drawx_r <= s1_drawx_r;
         s2_drawy_r <= s1_drawy_r;
         s2_vde_r   <= s1_vde_r;
         s2_hsync_r <= s1_hsync_r;
         s2_vsync_r <= s1_vsync_r;
         s2_col0_r  <= s1_col0_r;
      end
   end

   // Stage 3: register the glyph code and color word, forced black outside active video.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         draw_code <= 8'h00;
         draw_sig  <= 32'h0000_0000;
         DrawX_o   <= 10'd0;
         DrawY_o   <= 10'd0;
         vde_o     <= 1'b0;
         hsync_o   <= 1'b0;
         vsync_o   <= 1'b0;
      end else begin
         if (s2_vde_r) begin
            draw_code <= cell_s[15:8];
            draw_sig  <= {7'b0000000, fg_s, bg_s, 1'b0};
         end else begin
            draw_code <= 8'h00;
            draw_sig  <= 32'h0000_0000;
         end
         DrawX_o <= s2_drawx_r;
         DrawY_o <= s2_drawy_r;
         vde_o   <= s2_vde_r;
         hsync_o <= s2_hsync_r;
         vsync_o <= s2_vsync_r;
      end
   end

endmodule

// File: tb/tb_text_fetch_pipe.sv
// Randomized scoreboard bench for text_fetch_pipe with a behavioural VRAM and a pixel-level reference model.
module tb_text_fetch_pipe;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        vde, hsync, vsync;
   logic [10:0] vram_addr;
   logic        vram_re;
   logic [31:0] vram_rdata = 32'h0;
   logic        pal_we;
   logic [3:0]  pal_waddr;
   logic [11:0] pal_wdata;
   logic [7:0]  draw_code;
   logic [31:0] draw_sig;
   logic [9:0]  DrawX_o, DrawY_o;
   logic        vde_o, hsync_o, vsync_o;

   text_fetch_pipe dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
      .vde(vde), .hsync(hsync), .vsync(vsync),
      .vram_addr(vram_addr), .vram_re(vram_re), .vram_rdata(vram_rdata),
      .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
      .draw_code(draw_code), .draw_sig(draw_sig),
      .DrawX_o(DrawX_o), .DrawY_o(DrawY_o),
      .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vde;
      logic       hs;
      logic       vs;
   } pix_t;

   typedef struct packed {
      logic [7:0]  code;
      logic [31:0] sig;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        vde;
      logic        hs;
      logic        vs;
      logic [10:0] addr;
      logic        re;
   } out_t;

   out_t        exp_q[$];
   logic [31:0] mem [0:1199];
   logic [11:0] mpal [0:15];
   pix_t        h1, h2;
   logic        r1;
   logic [10:0] m_last_addr;
   int          checks = 0;
   int          passes = 0;
   string       phase = "init";

   // Synchronous VRAM with one-cycle read latency; every issued address must be in range.
   always @(posedge Clk) begin
      if (vram_re) begin
         checks++;
         if (vram_addr <= 11'd1199) begin
            passes++;
            vram_rdata <= mem[vram_addr];
         end else begin
            $display("FAIL vram_range (%s): addr=%0d required<=1199", phase, vram_addr);
         end
      end
   end

   function automatic pix_t mkpix(input int x, input int y, input bit v, input bit hs, input bit vs);
      pix_t p;
      p.x = 10'(x); p.y = 10'(y); p.vde = v; p.hs = hs; p.vs = vs;
      return p;
   endfunction

   // What a pixel should look like on screen: pure grid arithmetic on the model memory and palette.
   function automatic out_t ref_draw(input pix_t p);
      out_t o;
      int xi, yi, widx;
      logic [31:0] w;
      logic [15:0] c;
      o = '0;
      o.x = p.x; o.y = p.y; o.vde = p.vde; o.hs = p.hs; o.vs = p.vs;
      if (p.vde) begin
         xi = int'(p.x); yi = int'(p.y);
         widx = (yi / 16) * 40 + xi / 16;
         w = mem[widx];
         c = (((xi / 8) % 2) == 1) ? w[31:16] : w[15:0];
         o.code = c[15:8];
         o.sig  = {7'b0000000, mpal[c[7:4]], mpal[c[3:0]], 1'b0};
      end
      return o;
   endfunction

   task automatic step(input pix_t p, input bit rst, input bit pwe, input int pwa, input int pwd);
      out_t e;
      if (rst) begin
         e = '0;
         m_last_addr = 11'd0;
      end else begin
         e = r1 ? out_t'(0) : ref_draw(h2);
         if (p.vde) begin
            m_last_addr = 11'((int'(p.y) / 16) * 40 + int'(p.x) / 16);
            e.re = 1'b1;
         end
         e.addr = m_last_addr;
      end
      exp_q.push_back(e);
      if (rst) begin
         for (int i = 0; i < 16; i++) mpal[i] = 12'h000;
      end else if (pwe) begin
         mpal[pwa] = 12'(pwd);
      end
      h2 = h1;
      h1 = rst ? pix_t'(0) : p;
      r1 = rst;
      DrawX = p.x; DrawY = p.y; vde = p.vde; hsync = p.hs; vsync = p.vs;
      Reset = rst; pal_we = pwe; pal_waddr = 4'(pwa); pal_wdata = 12'(pwd);
      @(posedge Clk);
      #1;
   endtask

   // Monitor: every cycle the DUT presents a full output bundle, compared against the oldest expectation.
   always @(negedge Clk) begin
      out_t e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a.code = draw_code; a.sig = draw_sig; a.x = DrawX_o; a.y = DrawY_o;
         a.vde = vde_o; a.hs = hsync_o; a.vs = vsync_o; a.addr = vram_addr; a.re = vram_re;
         checks++;
         if (a === e) begin
            passes++;
         end else begin
            $display("FAIL out (%s): got code=%h sig=%h x=%0d y=%0d vde=%b hs=%b vs=%b addr=%0d re=%b, required code=%h sig=%h x=%0d y=%0d vde=%b hs=%b vs=%b addr=%0d re=%b",
                     phase, a.code, a.sig, a.x, a.y, a.vde, a.hs, a.vs, a.addr, a.re,
                     e.code, e.sig, e.x, e.y, e.vde, e.hs, e.vs, e.addr, e.re);
         end
      end
   end

   initial begin
      int ylines[6];
      pix_t blank;
      ylines = '{0, 15, 16, 239, 464, 479};
      blank = mkpix(700, 500, 1'b0, 1'b0, 1'b0);
      h1 = '0; h2 = '0; r1 = 1'b1; m_last_addr = 11'd0;
      for (int i = 0; i < 16; i++) mpal[i] = 12'h000;
      for (int i = 0; i < 1200; i++) mem[i] = $urandom;
      mem[5] = 32'hC12A_413F;

      phase = "reset";
      for (int i = 0; i < 3; i++) step(blank, 1'b1, 1'b1, i, 12'hABC);

      phase = "palinit";
      for (int i = 0; i < 16; i++) step(blank, 1'b0, 1'b1, i, int'($urandom_range(0, 4095)));
      step(blank, 1'b0, 1'b1, 3, 12'hF00);
      step(blank, 1'b0, 1'b1, 15, 12'h00F);
      step(blank, 1'b0, 1'b1, 2, 12'h0F0);
      step(blank, 1'b0, 1'b1, 10, 12'hFFF);

      phase = "decode";
      step(mkpix(80, 0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 0, 0);
      step(mkpix(88, 0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) step(mkpix(700, 0, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 0, 0);

      phase = "collide";
      step(mkpix(80, 0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 0, 0);
      step(mkpix(80, 0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 0, 0);
      step(blank, 1'b0, 1'b1, 3, 12'h0F0);
      step(blank, 1'b0, 1'b0, 0, 0);
      step(blank, 1'b0, 1'b0, 0, 0);

      phase = "lines";
      foreach (ylines[j]) begin
         for (int x = 0; x < 800; x++) begin
            step(mkpix(x, ylines[j], (x < 640), (x >= 656 && x < 752), 1'b0),
                 1'b0, (($urandom % 16) == 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)));
         end
      end

      phase = "reset_mid";
      for (int x = 0; x < 640; x++) begin
         step(mkpix(x, 100, 1'b1, 1'b0, 1'b0), (x == 300), (x == 300), 5, 12'h123);
      end

      phase = "random";
      for (int i = 0; i < 3000; i++) begin
         int x, y;
         bit v;
         x = int'($urandom_range(0, 799));
         y = int'($urandom_range(0, 524));
         v = (x < 640 && y < 480) ? (($urandom % 4) != 0) : 1'b0;
         step(mkpix(x, y, v, $urandom % 2, $urandom % 2),
              (($urandom % 64) == 0), (($urandom % 8) == 0),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)));
      end

      phase = "flush";
      for (int i = 0; i < 4; i++) step(blank, 1'b0, 1'b0, 0, 0);
      @(negedge Clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         passes++;
      end else begin
         $display("FAIL drain: %0d outputs pending, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
